single_cycle_cpu: RTL and testbench
===================================

SINGLE_CYCLE_CPU -- requirements
Module: single_cycle_cpu

Interface
REQ-001 The block SHALL have parameter IMEM_WORDS, default 128, meaning instruction memory depth in 32-bit words.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: run enable; when 1 the PC advances, when 0 the PC holds.
REQ-005 The block SHALL expose, for bench access, instance PC with 32-bit output pc_o holding the current program counter.
REQ-006 The block SHALL expose instance Instruction_Memory with array memory[0:IMEM_WORDS-1] of 32 bits, loadable by the bench before run.
REQ-007 The block SHALL expose instance Registers with array register[0:31] of 32 bits, writable and readable by the bench.

Function
REQ-008 The block SHALL execute one instruction per clk_i cycle (single-cycle datapath): fetch, decode, execute and write-back complete within one cycle.
REQ-009 Fetch SHALL be combinational: instruction = memory[pc_o[8:2]]; pc_o[1:0] ignored; index wraps modulo 128 words.
REQ-010 On each rising clk_i with rst_i=1 and start_i=1, pc_o SHALL become pc_o+4, modulo 2^32; no branches or jumps are supported.
REQ-011 With start_i=0, pc_o and all registers SHALL hold.
REQ-012 Register file reads (rs = instr[25:21], rt = instr[20:16]) SHALL be combinational; the write SHALL occur on the rising clk_i edge when enabled.
REQ-013 Writes to register[0] SHALL be discarded; register[0] SHALL read as 0.
REQ-014 R-type instructions (opcode 000000, rd = instr[15:11], result to rd) SHALL be decoded by funct:
- 100000 add: rs+rt
- 100010 sub: rs-rt
- 100100 and: rs&rt
- 100101 or: rs|rt
- 011000 mul: low 32 bits of rs*rt
REQ-015 Opcode 001000 addi SHALL write rt = rs + sign-extended instr[15:0].
REQ-016 All arithmetic SHALL be 32-bit two's complement wrapping; overflow SHALL NOT trap and SHALL set no flag.
REQ-017 An unrecognised opcode or funct, including the all-zero word (sll r0 form), SHALL perform no register write; PC still advances.
REQ-018 Register write-back SHALL be gated by start_i; with start_i=0 no register write occurs.
REQ-019 The write and the PC update SHALL use operands read before the edge; a same-cycle read-after-write SHALL see the old value.

Reset
REQ-020 When rst_i=0, pc_o SHALL be 0 immediately (asynchronously) and SHALL stay 0 while rst_i=0, regardless of start_i.
REQ-021 Register file and instruction memory SHALL NOT be cleared by reset; their contents are initialised by the bench.
REQ-022 No register write SHALL occur while rst_i=0.
REQ-023 On release of rst_i with start_i=1, the first instruction executed SHALL be memory[0], with pc_o=0, 4, 8, ... on successive edges.
REQ-024 Asserting rst_i mid-run SHALL return pc_o to 0 at once; register values already written SHALL persist.

Verification
REQ-025 Reset/hold: rst_i=0 for 2 edges with start_i=1 -> pc_o=0; release with start_i=0 -> pc_o stays 0; raise start_i -> pc_o=4 after the first edge.
REQ-026 addi/add: memory = {addi r8,r0,5; addi r9,r0,-3; add r10,r8,r9} -> after 3 edges r8=5, r9=0xFFFFFFFD, r10=2, pc_o=12.
REQ-027 ALU ops with r8=12, r9=10:
- sub r11,r8,r9 -> 2
- and r12 -> 8
- or r13 -> 14
- mul r14 -> 120
REQ-028 r0 protection: addi r0,r0,7 then add r16,r0,r0 -> r0=0, r16=0; a zero instruction word changes no register.
REQ-029 Wrap and PC overflow:
- addi r17,r0,0x7FFF; add r17 with itself repeatedly -> 32-bit wrap with no trap.
- 30 cycles of zero instructions -> pc_o=120, with no register changes.
- 130 cycles -> fetch index wraps to word 0.

Source files
------------

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-style datapath: add/sub/and/or/mul R-type plus addi, no branches.
// PC, instruction memory and register file are separate instances so the bench can reach them.

module pc_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] pc_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_o <= '0;
    else if (start)
      pc_o <= pc_o + 32'd4;
  end

endmodule

// Contents are preloaded from outside; the datapath only ever reads it.
module instruction_memory #(
  parameter int IMEM_WORDS = 128,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic [AW-1:0] index,
  output logic [31:0]   instr
);

  logic [31:0] memory [0:IMEM_WORDS-1];

  assign instr = memory[index];

endmodule

// Not cleared by reset; r0 is never written and always reads back as zero.
module register_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] register [0:31];

  always_ff @(posedge clk) begin
    if (we && rd != 5'd0)
      register[rd] <= wdata;
  end

  assign rs_data = (rs == 5'd0) ? 32'd0 : register[rs];
  assign rt_data = (rt == 5'd0) ? 32'd0 : register[rt];

endmodule

module single_cycle_cpu #(
  parameter int IMEM_WORDS = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] pc_o
);

  localparam int AW = $clog2(IMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_MUL   = 6'b011000;

  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] result;
  logic [31:0] imm_ext;
  logic [4:0]  wr_addr;
  logic        wr_valid;
  logic        wr_en;

  pc_reg PC (
    .clk   (clk_i),
    .rst_n (rst_i),
    .start (start_i),
    .pc_o  (pc_o)
  );

  instruction_memory #(.IMEM_WORDS(IMEM_WORDS)) Instruction_Memory (
    .index (pc_o[AW+1:2]),
    .instr (instr)
  );

  register_file Registers (
    .clk     (clk_i),
    .we      (wr_en),
    .rs      (instr[25:21]),
    .rt      (instr[20:16]),
    .rd      (wr_addr),
    .wdata   (result),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  // Unknown opcodes/functs leave wr_valid low, so they behave as no-ops.
  always_comb begin
    wr_valid = 1'b0;
    wr_addr  = instr[15:11];
    result   = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADD: begin result = rs_data + rt_data; wr_valid = 1'b1; end
          FN_SUB: begin result = rs_data - rt_data; wr_valid = 1'b1; end
          FN_AND: begin result = rs_data & rt_data; wr_valid = 1'b1; end
          FN_OR:  begin result = rs_data | rt_data; wr_valid = 1'b1; end
          FN_MUL: begin result = rs_data * rt_data; wr_valid = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        wr_addr  = instr[20:16];
        result   = rs_data + imm_ext;
        wr_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_en = wr_valid & start_i & rst_i;

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed and randomized bench for single_cycle_cpu against an instruction-level reference model.

module tb_single_cycle_cpu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] m_imem [128];
  logic [31:0] m_rf   [32];
  logic [31:0] m_pc;

  single_cycle_cpu #(.IMEM_WORDS(128)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .pc_o    (pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] addi(input int rt, input int rs, input int imm);
    return {6'b001000, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0) m_rf[idx] = val;
  endtask

  // One architectural instruction, evaluated from the inputs seen just before the edge.
  task automatic model_step();
    logic [31:0] ins, a, b;
    if (rst_i && start_i) begin
      ins = m_imem[(m_pc / 4) % 128];
      a = m_rf[ins[25:21]];
      b = m_rf[ins[20:16]];
      if (ins[31:26] == 6'd0) begin
        case (ins[5:0])
          6'h20: model_write(ins[15:11], a + b);
          6'h22: model_write(ins[15:11], a - b);
          6'h24: model_write(ins[15:11], a & b);
          6'h25: model_write(ins[15:11], a | b);
          6'h18: model_write(ins[15:11], 32'(a * b));
          default: ;
        endcase
      end else if (ins[31:26] == 6'd8) begin
        model_write(ins[20:16], a + 32'(int'(shortint'(ins[15:0]))));
      end
      m_pc = m_pc + 4;
    end
    if (!rst_i) m_pc = 0;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic load_word(input int i, input logic [31:0] w);
    m_imem[i] = w;
    dut.Instruction_Memory.memory[i] = w;
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    logic [31:0] val;
    val = (i == 0) ? 32'd0 : v;
    m_rf[i] = val;
    dut.Registers.register[i] = val;
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s r%0d", tag, i), dut.Registers.register[i], m_rf[i]);
    check({tag, " pc"}, pc_o, m_pc);
  endtask

  // Holds reset, empties the program and leaves the run disabled.
  task automatic reset_clear();
    rst_i   = 1'b0;
    start_i = 1'b0;
    m_pc    = 0;
    #1;
    for (int i = 0; i < 128; i++) load_word(i, 32'd0);
  endtask

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b1;
    m_pc    = 0;
    for (int i = 0; i < 32; i++) set_reg(i, $urandom);
    for (int i = 0; i < 128; i++) load_word(i, 32'd0);
    set_reg(21, 32'h1234_5678);
    load_word(0, addi(21, 0, 99));

    // Reset with run enabled: PC pinned to zero, no write-back.
    applyStimulus(2);
    check("reset pc", pc_o, 32'd0);
    check("reset no write r21", dut.Registers.register[21], 32'h1234_5678);
    rst_i = 1'b1;
    start_i = 1'b0;
    applyStimulus(1);
    check("hold pc", pc_o, 32'd0);
    check("hold no write r21", dut.Registers.register[21], 32'h1234_5678);
    start_i = 1'b1;
    applyStimulus(1);
    check("first edge pc", pc_o, 32'd4);
    check("first edge r21", dut.Registers.register[21], 32'd99);

    // addi / add sequence
    reset_clear();
    load_word(0, addi(8, 0, 5));
    load_word(1, addi(9, 0, -3));
    load_word(2, rtype(8, 9, 10, 6'h20));
    rst_i = 1'b1;
    start_i = 1'b1;
    applyStimulus(3);
    check("addi r8", dut.Registers.register[8], 32'd5);
    check("addi r9", dut.Registers.register[9], 32'hFFFF_FFFD);
    check("add r10", dut.Registers.register[10], 32'd2);
    check("seq pc", pc_o, 32'd12);

    // ALU operations
    reset_clear();
    set_reg(8, 12);
    set_reg(9, 10);
    load_word(0, rtype(8, 9, 11, 6'h22));
    load_word(1, rtype(8, 9, 12, 6'h24));
    load_word(2, rtype(8, 9, 13, 6'h25));
    load_word(3, rtype(8, 9, 14, 6'h18));
    rst_i = 1'b1;
    start_i = 1'b1;
    applyStimulus(4);
    check("sub r11", dut.Registers.register[11], 32'd2);
    check("and r12", dut.Registers.register[12], 32'd8);
    check("or r13", dut.Registers.register[13], 32'd14);
    check("mul r14", dut.Registers.register[14], 32'd120);

    // r0 protection and zero word
    reset_clear();
    set_reg(16, 32'hDEAD_BEEF);
    load_word(0, addi(0, 0, 7));
    load_word(1, rtype(0, 0, 16, 6'h20));
    rst_i = 1'b1;
    start_i = 1'b1;
    applyStimulus(3);
    check("r0 stays zero", dut.Registers.register[0], 32'd0);
    check("r16 from r0", dut.Registers.register[16], 32'd0);
    checkOutput("zero word");

    // Overflow wraps silently
    reset_clear();
    load_word(0, addi(17, 0, 16'h7FFF));
    for (int i = 1; i <= 20; i++) load_word(i, rtype(17, 17, 17, 6'h20));
    rst_i = 1'b1;
    start_i = 1'b1;
    applyStimulus(21);
    check("wrap r17", dut.Registers.register[17], 32'hFFF0_0000);
    check("wrap pc", pc_o, 32'd84);

    // 30 no-op cycles
    reset_clear();
    rst_i = 1'b1;
    start_i = 1'b1;
    applyStimulus(30);
    check("nop pc", pc_o, 32'd120);
    checkOutput("nop regs");

    // Fetch index wraps back to word 0
    reset_clear();
    set_reg(20, 0);
    load_word(0, addi(20, 20, 1));
    rst_i = 1'b1;
    start_i = 1'b1;
    applyStimulus(130);
    check("fetch wrap r20", dut.Registers.register[20], 32'd2);
    check("fetch wrap pc", pc_o, 32'd520);

    // Random program with random run enable and a mid-run reset
    reset_clear();
    for (int i = 1; i < 32; i++) set_reg(i, $urandom);
    for (int i = 0; i < 128; i++) begin
      logic [31:0] w;
      logic [5:0]  fns [5];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18};
      case ($urandom_range(0, 7))
        0, 1, 2, 3: w = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                              fns[$urandom_range(0, 4)]);
        4, 5:       w = addi($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        6:          w = 32'd0;
        default:    w = $urandom;
      endcase
      load_word(i, w);
    end
    rst_i = 1'b1;
    for (int c = 0; c < 300; c++) begin
      start_i = ($urandom_range(0, 3) != 0);
      if (c == 150) begin
        start_i = 1'b1;
        rst_i = 1'b0;
        #1;
        m_pc = 0;
        check("async reset pc", pc_o, 32'd0);
        applyStimulus(1);
        checkOutput("during reset");
        rst_i = 1'b1;
      end else begin
        applyStimulus(1);
        check($sformatf("rand pc c%0d", c), pc_o, m_pc);
        if (c % 25 == 24) checkOutput($sformatf("rand c%0d", c));
      end
    end
    checkOutput("rand final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
